hpdmc_refresh: RTL

Auto-refresh scheduler for the HPDMC SDRAM controller. It sits downstream of the control interface and consumes its `bypass`, `sdram_rst`, `tim_rp`, `tim_refi` and `tim_rfc` outputs. It counts out the refresh interval and arbitrates with the datapath through a request/grant handshake. Once granted, it drives a PRECHARGE ALL followed by an AUTO REFRESH onto the SDRAM command bus via the controller's command mux.

---
 rtl/hpdmc_refresh.sv | 102 ++++++++++
 1 files changed

// File: rtl/hpdmc_refresh.sv
// hpdmc_refresh: auto-refresh scheduler issuing PRECHARGE ALL + AUTO REFRESH
// after a request/grant handshake with the datapath.
module hpdmc_refresh #(
    parameter int max_pending = 7
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        bypass,
    input  logic        sdram_rst,
    input  logic [2:0]  tim_rp,
    input  logic [10:0] tim_refi,
    input  logic [3:0]  tim_rfc,
    output logic        refresh_req,
    input  logic        refresh_grant,
    output logic        refresh_busy,
    output logic        ref_cs_n,
    output logic        ref_ras_n,
    output logic        ref_cas_n,
    output logic        ref_we_n,
    output logic        ref_a10,
    output logic [2:0]  pending,
    output logic        overrun,
    input  logic        overrun_clr
);
    typedef enum logic [2:0] {IDLE, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC} state_t;
    localparam logic [3:0] cmd_nop = 4'b1111;
    localparam logic [3:0] cmd_pre = 4'b0010;
    localparam logic [3:0] cmd_ref = 4'b0001;
    localparam logic [2:0] max_p   = 3'(max_pending);
    state_t      state;
    logic [10:0] interval;
    logic [3:0]  cnt;
    logic        en, tick, done, full;
    assign en          = !bypass && !sdram_rst;
    assign tick        = en && interval == 11'd0;
    assign done        = en && ((state == REFRESH && tim_rfc == 4'd0) || (state == WAIT_RFC && cnt == 4'd0));
    assign full        = pending == max_p;
    // request is a decode of registered state so a new tick shows up one cycle later
    assign refresh_req = state == IDLE && pending != 3'd0;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            interval <= tim_refi;
            cnt <= 4'd0;
            pending <= 3'd0;
            overrun <= 1'b0;
            {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n} <= cmd_nop;
            ref_a10 <= 1'b0;
            refresh_busy <= 1'b0;
        end else begin
            overrun <= (tick && full && !done) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
            {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n} <= cmd_nop;
            ref_a10 <= 1'b0;
            if (!en) begin
                interval <= tim_refi;
                pending <= 3'd0;
                state <= IDLE;
                refresh_busy <= 1'b0;
            end else begin
                interval <= tick ? tim_refi : interval - 11'd1;
                // a tick and a completion in the same cycle cancel out
                if (tick && !done && !full)
                    pending <= pending + 3'd1;
                else if (done && !tick)
                    pending <= pending - 3'd1;
                case (state)
                    IDLE: if (refresh_req && refresh_grant) begin
                        state <= PRECHARGE;
                        {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n} <= cmd_pre;
                        ref_a10 <= 1'b1;
                        refresh_busy <= 1'b1;
                    end
                    PRECHARGE: if (tim_rp == 3'd0) begin
                        state <= REFRESH;
                        {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n} <= cmd_ref;
                    end else begin
                        state <= WAIT_RP;
                        cnt <= {1'b0, tim_rp} - 4'd1;
                    end
                    WAIT_RP: if (cnt == 4'd0) begin
                        state <= REFRESH;
                        {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n} <= cmd_ref;
                    end else
                        cnt <= cnt - 4'd1;
                    REFRESH: if (tim_rfc == 4'd0) begin
                        state <= IDLE;
                        refresh_busy <= 1'b0;
                    end else begin
                        state <= WAIT_RFC;
                        cnt <= tim_rfc - 4'd1;
                    end
                    WAIT_RFC: if (cnt == 4'd0) begin
                        state <= IDLE;
                        refresh_busy <= 1'b0;
                    end else
                        cnt <= cnt - 4'd1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
